// File: rtl/seq_gen_arbiter_if.sv
// seq_gen_arbiter_if: requester/generator bundle for seq_gen_arbiter.
// master = requester/generator side, slave = the arbiter.
interface seq_gen_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       gnt;
  logic                     seq_en;
  logic [DATA_W-1:0]        seq_data;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     busy;

  modport master (
    output req, req_len, seq_data,
    input  gnt, seq_en, out_data, out_valid, out_last, busy
  );

  modport slave (
    input  req, req_len, seq_data,
    output gnt, seq_en, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/seq_gen_arbiter.sv
// seq_gen_arbiter: round-robin sharing of one sequence generator between
// NUM_REQ requesters. Each grant runs a burst of req_len+1 generator steps;
// returned values are forwarded one cycle later with valid/last.
// Optional macro SEQ_GEN_ARB_GAP_EN adds a one-cycle GAP state after DRAIN.
module seq_gen_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4
) (
  input logic              clk,
  input logic              rst,
  seq_gen_arbiter_if.slave bus
);
  localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR    = NUM_REQ;

`ifdef SEQ_GEN_ARB_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
`endif

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_sel;
  logic [LEN_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_seq_en;
  logic               r_busy;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_valid;
  logic               r_out_last;

  logic               w_any;
  logic [PTR_W-1:0]   w_sel;
  logic [LEN_W-1:0]   w_len;
  logic [NUM_REQ-1:0] w_onehot;
  int unsigned        w_best;
  int unsigned        w_dist;

  // Pick the requester closest (upward, wrapping) to the round-robin pointer.
  // Ranking by rotated distance keeps every select index constant.
  always_comb begin
    w_any    = |bus.req;
    w_sel    = '0;
    w_len    = '0;
    w_best   = NR;
    w_dist   = 0;
    w_onehot = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      w_dist = (i + NR - 32'(r_ptr)) % NR;
      if (bus.req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = PTR_W'(i);
        w_len  = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
    w_onehot[w_sel] = 1'b1;
  end

  // Control FSM: grant, step counting, drain and pointer rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_seq_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt    <= w_onehot;
            r_sel    <= w_sel;
            r_cnt    <= w_len;
            r_seq_en <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            r_seq_en <= 1'b0;
            r_state  <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          r_gnt <= '0;
          r_ptr <= (r_sel == PTR_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
`ifdef SEQ_GEN_ARB_GAP_EN
          r_state <= S_GAP;
`else
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
`endif
        end
`ifdef SEQ_GEN_ARB_GAP_EN
        S_GAP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
`endif
        default: begin
          r_state  <= S_IDLE;
          r_gnt    <= '0;
          r_seq_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // Return path: one register stage behind seq_en; last marks the step taken at count 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= r_seq_en;
      r_out_data  <= bus.seq_data;
      r_out_last  <= r_seq_en && (r_cnt == '0);
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.seq_en    = r_seq_en;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_seq_gen_arbiter.sv
// tb_seq_gen_arbiter: table-driven and randomized check of seq_gen_arbiter
// against a burst-level reference model and an 8-entry sequence generator.
module tb_seq_gen_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 4;
`ifdef SEQ_GEN_ARB_GAP_EN
  localparam int   EXP_GAP      = 3;
  localparam logic EXP_BUSY_END = 1'b1;
`else
  localparam int   EXP_GAP      = 2;
  localparam logic EXP_BUSY_END = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_gen_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW)) bus ();

  seq_gen_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Sequence generator stand-in: 8 entries, steps when seq_en is sampled high.
  logic [2:0] gidx;
  logic       gen_rst;

  function automatic logic [7:0] tabv(input int i);
    return 8'(32'hA5 + 32'(i % 8) * 32'h1D);
  endfunction

  always @(posedge clk) begin
    if (gen_rst)         gidx <= '0;
    else if (bus.seq_en) gidx <= gidx + 3'd1;
  end
  assign bus.seq_data = tabv(int'(gidx));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int exp_ptr;
  int exp_gidx;
  int last_en_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Whole-run invariants
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("valid_without_gnt", 32'(bus.out_valid && (bus.gnt == '0)), 32'd0);
      chk("idle_drive", 32'(!bus.busy && ((bus.gnt != '0) || bus.seq_en)), 32'd0);
    end
  end

  function automatic int model_sel(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic gen_reset();
    bus.req  = '0;
    gen_rst  = 1'b1;
    @(negedge clk);
    gen_rst  = 1'b0;
    exp_gidx = 0;
  endtask

  // Run one burst from the IDLE negedge and compare it with the expectation.
  task automatic burst(input logic [N-1:0] rv, input logic [N*LW-1:0] lf, input bit hold,
                       input logic [N-1:0] xg, input int xc, input bit gapchk, input string nm);
    int n, en_cnt, vcnt, fe, le;
    bus.req     = rv;
    bus.req_len = lf;
    n = 0;
    while (bus.gnt == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.gnt == '0) begin
      chk({nm, "_gnt_timeout"}, 32'(bus.gnt), 32'(xg));
      return;
    end
    chk({nm, "_gnt"}, 32'(bus.gnt), 32'(xg));
    if (!hold) bus.req = rv & ~bus.gnt;
    en_cnt = 0; vcnt = 0; fe = -1; le = -1; n = 0;
    while (bus.gnt != '0 && n < 60) begin
      chk({nm, "_gnt_hold"}, 32'(bus.gnt), 32'(xg));
      if (bus.seq_en) begin
        en_cnt++;
        if (fe < 0) fe = cyc;
        le = cyc;
      end
      if (bus.out_valid) begin
        chk({nm, "_data"}, 32'(bus.out_data), 32'(tabv(exp_gidx + vcnt)));
        chk({nm, "_last"}, 32'(bus.out_last), 32'(vcnt == xc - 1));
        vcnt++;
      end else begin
        chk({nm, "_last_idle"}, 32'(bus.out_last), 32'd0);
      end
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk({nm, "_end_timeout"}, 32'(bus.gnt), 32'd0);
    chk({nm, "_en_cnt"}, 32'(en_cnt), 32'(xc));
    chk({nm, "_valid_cnt"}, 32'(vcnt), 32'(xc));
    chk({nm, "_busy_end"}, 32'(bus.busy), 32'(EXP_BUSY_END));
    if (gapchk) chk({nm, "_gap"}, 32'(fe - last_en_cyc - 1), 32'(EXP_GAP));
    last_en_cyc = le;
    exp_gidx += xc;
    for (int k = 0; k < N; k++) if (xg[k]) exp_ptr = (k + 1) % N;
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [N*LW-1:0] lens;
    bit              hold;
    bit              grst;
    bit              gapchk;
    logic [N-1:0]    xg;
    int              xc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, v;
    rst = 1'b1; gen_rst = 1'b1;
    bus.req = '0; bus.req_len = '0;
    exp_ptr = 0; exp_gidx = 0; last_en_cyc = 0;

    tbl[0]  = '{4'b0010, 16'h0030, 1'b0, 1'b1, 1'b0, 4'b0010, 4};
    tbl[1]  = '{4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1};
    tbl[2]  = '{4'b0100, 16'h0F00, 1'b0, 1'b1, 1'b0, 4'b0100, 16};
    tbl[3]  = '{4'b0100, 16'h0300, 1'b0, 1'b0, 1'b0, 4'b0100, 4};
    tbl[4]  = '{4'b1000, 16'h2000, 1'b0, 1'b0, 1'b0, 4'b1000, 3};
    tbl[5]  = '{4'b1111, 16'h1111, 1'b1, 1'b0, 1'b0, 4'b0001, 2};
    tbl[6]  = '{4'b1111, 16'h1111, 1'b1, 1'b0, 1'b1, 4'b0010, 2};
    tbl[7]  = '{4'b1111, 16'h1111, 1'b1, 1'b0, 1'b1, 4'b0100, 2};
    tbl[8]  = '{4'b1111, 16'h1111, 1'b1, 1'b0, 1'b1, 4'b1000, 2};
    tbl[9]  = '{4'b1111, 16'h1111, 1'b0, 1'b0, 1'b1, 4'b0001, 2};
    tbl[10] = '{4'b0011, 16'h0022, 1'b1, 1'b0, 1'b0, 4'b0010, 3};
    tbl[11] = '{4'b0011, 16'h0022, 1'b0, 1'b0, 1'b1, 4'b0001, 3};

    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_seq_en", 32'(bus.seq_en), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0; gen_rst = 1'b0; mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].grst) gen_reset();
      burst(tbl[i].req, tbl[i].lens, tbl[i].hold, tbl[i].xg, tbl[i].xc, tbl[i].gapchk,
            $sformatf("vec%0d", i));
    end
    bus.req = '0;

    // Reset in the middle of an 8-step burst after three values
    gen_reset();
    bus.req = 4'b0001; bus.req_len = 16'h0007;
    n = 0; v = 0;
    while (v < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) v++;
    end
    chk("midrst_vals_before", 32'(v), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(bus.gnt), 32'd0);
    chk("midrst_seq_en", 32'(bus.seq_en), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_last", 32'(bus.out_last), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("postrst_busy", 32'(bus.busy), 32'd0);
    chk("postrst_gnt", 32'(bus.gnt), 32'd0);
    exp_ptr = 0;

    // Request already high when reset is released
    rst = 1'b1; gen_rst = 1'b1;
    bus.req = 4'b0100; bus.req_len = '0;
    @(negedge clk);
    rst = 1'b0; gen_rst = 1'b0; exp_gidx = 0;
    @(negedge clk);
    chk("release_gnt", 32'(bus.gnt), 32'b0100);
    burst(4'b0100, 16'h0000, 1'b0, 4'b0100, 1, 1'b0, "release");

    // Randomized bursts against the model
    for (int it = 0; it < 40; it++) begin
      logic [N-1:0]    rv;
      logic [N*LW-1:0] lf;
      int              s;
      rv = N'($urandom_range(1, 15));
      lf = (N*LW)'($urandom);
      s  = model_sel(rv, exp_ptr);
      burst(rv, lf, 1'($urandom_range(0, 1)), N'(1) << s, int'(lf[s*LW +: LW]) + 1, 1'b0,
            $sformatf("rand%0d", it));
    end
    bus.req = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
